// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg: op-codes and FSM state encoding shared by the seq_alu slice  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_MUL  = 1'b1;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/logic_unit_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_unit_n: N-bit combinational AND/OR/XOR/NOR select               |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module logic_unit_n #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            2'b10:   y = a ^ b;
            default: y = ~(a | b);
        endcase
    end

endmodule : logic_unit_n
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_alu: clocked N-bit ALU with handshake and shift-add multiplier    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mplr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_ovf;
    logic             r_done;

    logic [WIDTH-1:0] w_logic;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_accept;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_mplr_nxt;
    logic             w_mul_last;

    logic_unit_n #(
        .WIDTH (WIDTH)
    ) u_logic (
        .a   (a),
        .b   (b),
        .sel (op[1:0]),
        .y   (w_logic)
    );

    // Single-cycle datapath
    assign w_sum  = a + b;
    assign w_diff = a - b;
    assign w_lt   = $signed(a) < $signed(b);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NOR: w_res = w_logic;
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
            default: w_res = '0;
        endcase
    end

    // One shift-add step on the {acc, multiplier} product register; carry kept in bit WIDTH
    assign w_mul_sum  = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_nxt  = w_mul_sum[WIDTH:1];
    assign w_mplr_nxt = {w_mul_sum[0], r_mplr[WIDTH-1:1]};
    assign w_mul_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start && op == OP_MUL) w_state_nxt = ST_MUL;
            ST_MUL:  if (w_mul_last)            w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready    = (r_state == ST_IDLE);
        w_accept = ready && start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplr   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                if (op == OP_MUL) begin
                    r_mcand <= a;
                    r_mplr  <= b;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_result <= w_res;
                    r_hi     <= '0;
                    r_zero   <= (w_res == '0);
                    r_ovf    <= w_ovf;
                    r_done   <= 1'b1;
                end
            end else if (r_state == ST_MUL) begin
                r_acc  <= w_acc_nxt;
                r_mplr <= w_mplr_nxt;
                r_cnt  <= r_cnt + CNT_W'(1);
                if (w_mul_last) begin
                    r_result <= w_mplr_nxt;
                    r_hi     <= w_acc_nxt;
                    r_zero   <= (w_mplr_nxt == '0);
                    r_ovf    <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign done     = r_done;
    assign result   = r_result;
    assign hi       = r_hi;
    assign zero     = r_zero;
    assign overflow = r_ovf;

endmodule : seq_alu
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_alu: randomized self-checking bench for seq_alu (WIDTH=32)     |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_seq_alu;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             overflow;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        ovf;
    } exp_t;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .hi       (hi),
        .zero     (zero),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference computed from signed/unsigned integer arithmetic on wide types
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint sx, sy, s;
        logic [63:0] p;
        e  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: e.res = x & y;
            3'd1: e.res = x | y;
            3'd2: e.res = x ^ y;
            3'd3: e.res = ~(x | y);
            3'd4: begin
                s     = sx + sy;
                e.res = s[31:0];
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd5: begin
                s     = sx - sy;
                e.res = s[31:0];
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd6: e.res = (sx < sy) ? 32'd1 : 32'd0;
            default: begin
                p     = {32'd0, x} * {32'd0, y};
                e.res = p[31:0];
                e.hi  = p[63:32];
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Called just after a rising edge; issues the op at the next edge and waits for done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit intrude);
        exp_t e;
        int   n;
        bit   busy_ok;
        e     = model(o, x, y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 3'($urandom);
        if (o == 3'd7) begin
            n       = 0;
            busy_ok = 1'b1;
            while (!done && n < 100) begin
                if (ready) busy_ok = 1'b0;
                if (intrude) begin
                    start = 1'b1;
                    op    = 3'd0;
                end
                @(posedge clk);
                #1;
                n++;
                if (done) start = 1'b0;
            end
            start = 1'b0;
            check("mul_latency", 64'(n), 64'(WIDTH));
            check("mul_busy_ready", 64'(busy_ok), 64'd1);
        end
        check("done", 64'(done), 64'd1);
        check("ready_after", 64'(ready), 64'd1);
        check("result", 64'(result), 64'(e.res));
        check("hi", 64'(hi), 64'(e.hi));
        check("zero", 64'(zero), 64'(e.res == 32'd0));
        check("overflow", 64'(overflow), 64'(e.ovf));
    endtask

    initial begin
        int dcount;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        #12;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op(3'd0, 32'h9000_000A, 32'h1000_001E, 1'b0);
        check("and_value", 64'(result), 64'h1000_000A);
        run_op(3'd4, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check("add_ovf_value", 64'(overflow), 64'd1);
        run_op(3'd5, 32'h1234_5678, 32'h1234_5678, 1'b0);
        check("sub_zero_value", 64'(zero), 64'd1);
        run_op(3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check("slt_value", 64'(result), 64'd1);
        run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("mul_max_hi", 64'(hi), 64'hFFFF_FFFE);
        run_op(3'd7, 32'd6, 32'd7, 1'b1);
        check("mul_small", 64'(result), 64'd42);

        // done must drop after its single cycle when nothing new is issued
        @(posedge clk);
        #1;
        check("done_pulse", 64'(done), 64'd0);

        // Reset in the middle of a multiply aborts it
        start = 1'b1;
        op    = 3'd7;
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_zero", 64'(zero), 64'd0);
        check("abort_ovf", 64'(overflow), 64'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'd0);
        run_op(3'd1, 32'h0000_00F0, 32'h0000_000F, 1'b0);
        check("or_after_abort", 64'(result), 64'hFF);

        // Random back-to-back traffic: each op is issued in the previous done cycle
        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom), rand_operand(), rand_operand(), 1'($urandom));
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_seq_alu
`default_nettype wire
